// File: rtl/mux_pkg.sv
// Shared types for the N-to-1 stream multiplexer: selection mode and packet-lock state.
package mux_pkg;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mux_mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

endpackage

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// Combinational rotate-priority search: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          gnt_valid,
    output logic [PW-1:0] gnt_idx
);

    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            // One spare bit holds ptr+k before folding back into 0..N-1.
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            cand = sum[PW-1:0];
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/stream_mux_nx1.sv
// N-input valid/ready stream mux with packet lock, sel or round-robin grant,
// and a single-entry registered output stage.
module stream_mux_nx1
    import mux_pkg::*;
#(
    parameter int        WIDTH = 32,
    parameter int        N_IN  = 4,
    parameter mux_mode_e MODE  = MODE_SEL,
    parameter int        SEL_W = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN-1:0]       in_last,
    output logic [N_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [SEL_W-1:0]      out_src,
    input  logic                  out_ready
);

    lock_state_e      state_q, state_d;
    logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [SEL_W-1:0] out_src_q, out_src_d;

    logic             rr_gnt_valid;
    logic [SEL_W-1:0] rr_gnt_idx;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic             load_en;
    logic             xfer;
    logic             beat_last;
    logic [WIDTH-1:0] beat_data;

    rr_arbiter #(
        .N  (N_IN),
        .PW (SEL_W)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    // A locked packet owns the datapath; otherwise sel or the arbiter decides.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (state_q == LOCKED) begin
            grant       = lock_ch_q;
            grant_valid = in_valid[lock_ch_q];
        end else if (MODE == MODE_RR) begin
            grant       = rr_gnt_idx;
            grant_valid = rr_gnt_valid;
        end else if ({1'b0, sel} < (SEL_W+1)'(N_IN)) begin
            grant       = sel;
            grant_valid = in_valid[sel];
        end
    end

    assign load_en   = !out_valid_q || out_ready;
    assign beat_last = in_last[grant];
    assign beat_data = in_data[int'(grant)*WIDTH +: WIDTH];

    // rst_n gates ready so nothing handshakes while reset is held.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = rst_n && load_en && grant_valid && (grant == SEL_W'(i));
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data;
            out_last_d  = beat_last;
            out_src_d   = grant;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (xfer) begin
            if (beat_last) begin
                state_d  = IDLE;
                rr_ptr_d = (grant == SEL_W'(N_IN-1)) ? '0 : grant + 1'b1;
            end else if (state_q == IDLE) begin
                state_d   = LOCKED;
                lock_ch_d = grant;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            lock_ch_q   <= lock_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Scoreboard bench: per-channel source queues feed a sel-mode, a round-robin and a
// 3-input mux; a monitor pops expected beats whenever an output beat is accepted.
module tb_stream_mux_nx1;
    import mux_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4*W-1:0] in_data_s, in_data_r;
    logic [3:0]     in_valid_s, in_valid_r, in_last_s, in_last_r, in_ready_s, in_ready_r;
    logic [1:0]     sel_s, sel_r, out_src_s, out_src_r;
    logic [W-1:0]   out_data_s, out_data_r;
    logic           out_valid_s, out_valid_r, out_last_s, out_last_r, out_ready_s, out_ready_r;

    logic [3*W-1:0] in_data_3;
    logic [2:0]     in_valid_3, in_last_3, in_ready_3;
    logic [1:0]     sel_3, out_src_3;
    logic [W-1:0]   out_data_3;
    logic           out_valid_3, out_last_3, out_ready_3;

    stream_mux_nx1 #(.WIDTH(W), .N_IN(4), .MODE(MODE_SEL)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_s), .in_valid(in_valid_s),
        .in_last(in_last_s), .in_ready(in_ready_s), .sel(sel_s), .out_data(out_data_s),
        .out_valid(out_valid_s), .out_last(out_last_s), .out_src(out_src_s),
        .out_ready(out_ready_s));

    stream_mux_nx1 #(.WIDTH(W), .N_IN(4), .MODE(MODE_RR)) dut_r (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_r), .in_valid(in_valid_r),
        .in_last(in_last_r), .in_ready(in_ready_r), .sel(sel_r), .out_data(out_data_r),
        .out_valid(out_valid_r), .out_last(out_last_r), .out_src(out_src_r),
        .out_ready(out_ready_r));

    stream_mux_nx1 #(.WIDTH(W), .N_IN(3), .MODE(MODE_SEL)) dut_3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_3), .in_valid(in_valid_3),
        .in_last(in_last_3), .in_ready(in_ready_3), .sel(sel_3), .out_data(out_data_3),
        .out_valid(out_valid_3), .out_last(out_last_3), .out_src(out_src_3),
        .out_ready(out_ready_3));

    logic [W:0]   q_s [4][$];
    logic [W:0]   q_r [4][$];
    logic [W+2:0] exp_s [$];
    logic [W+2:0] exp_r [$];
    logic [3:0]   hs_s = '0;
    logic [3:0]   hs_r = '0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic src(input bit rr, input int ch, input logic last, input logic [W-1:0] d);
        if (rr) q_r[ch].push_back({last, d});
        else    q_s[ch].push_back({last, d});
    endtask

    task automatic expect_beat(input bit rr, input int ch, input logic last, input logic [W-1:0] d);
        if (rr) exp_r.push_back({last, 2'(ch), d});
        else    exp_s.push_back({last, 2'(ch), d});
    endtask

    task automatic drive();
        logic [W:0] b;
        for (int i = 0; i < 4; i++) begin
            b = '0;
            if (q_s[i].size() > 0) b = q_s[i][0];
            in_valid_s[i]       = (q_s[i].size() > 0);
            in_data_s[i*W +: W] = b[W-1:0];
            in_last_s[i]        = b[W];
            b = '0;
            if (q_r[i].size() > 0) b = q_r[i][0];
            in_valid_r[i]       = (q_r[i].size() > 0);
            in_data_r[i*W +: W] = b[W-1:0];
            in_last_r[i]        = b[W];
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_s.size() > 0 || exp_r.size() > 0) && c < 60) begin
            @(negedge clk);
            c++;
        end
        if (exp_s.size() > 0 || exp_r.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: left sel=%0d rr=%0d expected 0", exp_s.size(), exp_r.size());
        end
    endtask

    // Handshakes are captured at the active edge; sources advance just after it.
    always @(posedge clk) begin
        hs_s <= in_valid_s & in_ready_s;
        hs_r <= in_valid_r & in_ready_r;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs_s[i] && q_s[i].size() > 0) q_s[i].delete(0);
                if (hs_r[i] && q_r[i].size() > 0) q_r[i].delete(0);
            end
            drive();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid_s && out_ready_s) begin
                if (exp_s.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sel_unexpected_beat: got %h expected none", out_data_s);
                end else begin
                    chk("sel_beat", 64'({out_last_s, out_src_s, out_data_s}), 64'(exp_s.pop_front()));
                end
            end
            if (rst_n === 1'b1 && out_valid_r && out_ready_r) begin
                if (exp_r.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rr_unexpected_beat: got %h expected none", out_data_r);
                end else begin
                    chk("rr_beat", 64'({out_last_r, out_src_r, out_data_r}), 64'(exp_r.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sel_seq [3];
        sel_seq[0] = 2'd0; sel_seq[1] = 2'd1; sel_seq[2] = 2'd3;

        rst_n = 1'b0;
        sel_s = 2'd2; sel_r = 2'd0; out_ready_s = 1'b1; out_ready_r = 1'b1;
        in_valid_3 = 3'b111; in_last_3 = 3'b111; sel_3 = 2'd3; out_ready_3 = 1'b1;
        in_data_3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

        // All channels valid under reset; sel picks 2, 0, 1, 3 in turn afterwards.
        src(0, 0, 1'b1, 32'h1000_0000);
        src(0, 1, 1'b1, 32'h1000_0001);
        src(0, 2, 1'b1, 32'hA5A5_0002);
        src(0, 3, 1'b1, 32'h1000_0003);
        expect_beat(0, 2, 1'b1, 32'hA5A5_0002);
        expect_beat(0, 0, 1'b1, 32'h1000_0000);
        expect_beat(0, 1, 1'b1, 32'h1000_0001);
        expect_beat(0, 3, 1'b1, 32'h1000_0003);
        for (int rep = 0; rep < 2; rep++) begin
            for (int ch = 0; ch < 4; ch++) begin
                src(1, ch, 1'b1, 32'h2000_0000 + 32'(rep*16 + ch));
                expect_beat(1, ch, 1'b1, 32'h2000_0000 + 32'(rep*16 + ch));
            end
        end
        drive();

        repeat (3) @(negedge clk);
        chk("rst_out_valid_s", 64'(out_valid_s), 64'd0);
        chk("rst_out_data_s", 64'(out_data_s), 64'd0);
        chk("rst_in_ready_s", 64'(in_ready_s), 64'd0);
        chk("rst_in_ready_r", 64'(in_ready_r), 64'd0);
        chk("rst_out_valid_r", 64'(out_valid_r), 64'd0);
        chk("rst_in_ready_3", 64'(in_ready_3), 64'd0);

        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_s", 64'(in_ready_s), 64'h4);
        chk("rel_in_ready_r", 64'(in_ready_r), 64'h1);
        chk("rel_out_valid_s", 64'(out_valid_s), 64'd0);

        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 3) sel_s = sel_seq[k];
            @(negedge clk);
            chk("rr_valid_each_cycle", 64'(out_valid_r), 64'd1);
            chk("rr_src_order", 64'(out_src_r), 64'(k % 4));
            if (k == 0) begin
                chk("sel_first_valid", 64'(out_valid_s), 64'd1);
                chk("sel_first_src", 64'(out_src_s), 64'd2);
                chk("sel_first_last", 64'(out_last_s), 64'd1);
                chk("sel_first_data", 64'(out_data_s), 64'hA5A5_0002);
            end
        end
        wait_drain();

        // Move rr_ptr to 1, then ch1's 3-beat packet must hold off ch2 and ch0.
        @(posedge clk);
        #1;
        src(1, 0, 1'b1, 32'h3000_0000);
        expect_beat(1, 0, 1'b1, 32'h3000_0000);
        drive();
        @(posedge clk);
        #1;
        src(1, 1, 1'b0, 32'h3100_0000);
        src(1, 1, 1'b0, 32'h3100_0001);
        src(1, 1, 1'b1, 32'h3100_0002);
        src(1, 0, 1'b1, 32'h3000_0001);
        src(1, 2, 1'b1, 32'h3200_0000);
        expect_beat(1, 1, 1'b0, 32'h3100_0000);
        expect_beat(1, 1, 1'b0, 32'h3100_0001);
        expect_beat(1, 1, 1'b1, 32'h3100_0002);
        expect_beat(1, 2, 1'b1, 32'h3200_0000);
        expect_beat(1, 0, 1'b1, 32'h3000_0001);
        drive();
        wait_drain();

        // sel moves 1 -> 3 after the first beat; the lock keeps ch1 to its last beat.
        @(posedge clk);
        #1;
        sel_s = 2'd1;
        src(0, 1, 1'b0, 32'h4100_0000);
        src(0, 1, 1'b0, 32'h4100_0001);
        src(0, 1, 1'b1, 32'h4100_0002);
        src(0, 3, 1'b1, 32'h4300_0000);
        expect_beat(0, 1, 1'b0, 32'h4100_0000);
        expect_beat(0, 1, 1'b0, 32'h4100_0001);
        expect_beat(0, 1, 1'b1, 32'h4100_0002);
        expect_beat(0, 3, 1'b1, 32'h4300_0000);
        drive();
        @(posedge clk);
        #1;
        sel_s = 2'd3;
        @(negedge clk);
        chk("sel_lock_in_ready", 64'(in_ready_s), 64'h2);
        wait_drain();

        // Backpressure: one beat held five cycles, then retire and reload together.
        @(posedge clk);
        #1;
        out_ready_s = 1'b0;
        sel_s = 2'd0;
        src(0, 0, 1'b1, 32'h5000_0000);
        src(0, 0, 1'b1, 32'h5000_0001);
        expect_beat(0, 0, 1'b1, 32'h5000_0000);
        expect_beat(0, 0, 1'b1, 32'h5000_0001);
        drive();
        @(negedge clk);
        chk("bp_first_in_ready", 64'(in_ready_s), 64'h1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(out_valid_s), 64'd1);
            chk("bp_hold_data", 64'(out_data_s), 64'h5000_0000);
            chk("bp_hold_in_ready", 64'(in_ready_s), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready_s = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready_s), 64'h1);
        @(negedge clk);
        chk("bp_reload_valid", 64'(out_valid_s), 64'd1);
        chk("bp_reload_data", 64'(out_data_s), 64'h5000_0001);
        @(negedge clk);
        chk("bp_retire_valid", 64'(out_valid_s), 64'd0);
        chk("bp_retire_data_kept", 64'(out_data_s), 64'h5000_0001);

        // Three inputs: sel=3 has no channel behind it.
        chk("n3_no_grant_ready", 64'(in_ready_3), 64'd0);
        chk("n3_no_grant_valid", 64'(out_valid_3), 64'd0);
        @(posedge clk);
        #1;
        sel_3 = 2'd2;
        @(negedge clk);
        chk("n3_sel2_ready", 64'(in_ready_3), 64'h4);
        @(negedge clk);
        chk("n3_sel2_valid", 64'(out_valid_3), 64'd1);
        chk("n3_sel2_src", 64'(out_src_3), 64'd2);
        chk("n3_sel2_data", 64'(out_data_3), 64'h3333_0002);

        // Reset lands mid-packet while the first beat is held by backpressure.
        @(posedge clk);
        #1;
        out_ready_r = 1'b0;
        src(1, 2, 1'b0, 32'h6200_0000);
        src(1, 2, 1'b0, 32'h6200_0001);
        drive();
        @(posedge clk);
        @(posedge clk);
        #3;
        chk("mid_pkt_valid", 64'(out_valid_r), 64'd1);
        chk("mid_pkt_data", 64'(out_data_r), 64'h6200_0000);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(out_valid_r), 64'd0);
        chk("async_rst_data", 64'(out_data_r), 64'd0);
        chk("async_rst_src", 64'(out_src_r), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready_r), 64'd0);
        @(negedge clk);
        q_r[2].delete();
        out_ready_r = 1'b1;
        src(1, 0, 1'b1, 32'h7000_0000);
        expect_beat(1, 0, 1'b1, 32'h7000_0000);
        drive();
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle_grant", 64'(in_ready_r), 64'h1);
        wait_drain();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_nx1.md
Name: stream_mux_nx1

Overview:
- Parametrised N-input, WIDTH-bit stream multiplexer with valid/ready handshakes and a registered output stage.
- Two selection modes:
  - MODE_SEL: the external sel port picks the input.
  - MODE_RR: round-robin arbitration across requesting inputs.
- Multi-beat packets: once a packet starts, the grant stays on that input until its last beat is transferred.
- Used wherever multiple producers share one datapath consumer, e.g. writeback/bus sources feeding a single port.

Parameters:
- WIDTH, 32, data bits per channel.
- N_IN, 4, number of input channels (>= 2; need not be a power of two).
- MODE, MODE_SEL, selection mode (mux_pkg::mux_mode_e: MODE_SEL or MODE_RR).
- SEL_W, $clog2(N_IN), derived width of sel and out_src; not intended for override.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N_IN*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel valid.
- in_last  in  N_IN  per-channel end-of-packet flag, qualified by in_valid.
- in_ready  out  N_IN  per-channel ready; at most one bit high in any cycle.
- sel  in  SEL_W  channel select; used only in MODE_SEL.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  output holds a beat.
- out_last  out  1  registered copy of the accepted beat's in_last.
- out_src  out  SEL_W  index of the channel that supplied the current output beat.
- out_ready  in  1  consumer accepts the output beat.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_last=0, out_src=0, rr_ptr=0, FSM=IDLE, in_ready all 0. All of these hold while rst_n is low.
- Output stage is a single entry:
  - load_en = !out_valid || out_ready.
  - Input beat to output: latency 1 cycle.
  - Sustained throughput: 1 beat/cycle.
- Transfer on input i: in_valid[i] && in_ready[i]. On that edge, out_data, out_last and out_src (=i) are loaded and out_valid is set to 1.
- Output retire: out_valid && out_ready && no new load. On that edge out_valid is cleared to 0; out_data is kept.
- Output register stability: out_data, out_last and out_src do not change while out_valid && !out_ready.
- FSM states: IDLE, LOCKED. It holds lock_ch (SEL_W bits).
- IDLE, grant choice:
  - MODE_SEL: the candidate is sel. It is granted only if sel < N_IN and in_valid[sel]=1.
  - MODE_RR: search for the first valid channel, starting at rr_ptr and wrapping modulo N_IN (N_IN-1 wraps to 0).
- IDLE, transfer outcomes:
  - Transfer with in_last=1: stay in IDLE.
  - Transfer with in_last=0: go to LOCKED and set lock_ch=granted index.
- LOCKED:
  - The grant is forced to lock_ch, regardless of sel or other requests.
  - A transfer with in_last=1 returns the FSM to IDLE.
- in_ready[i] = load_en && grant_valid && (grant==i). It does not depend combinationally on in_valid of other channels except through arbitration. It never depends on out_valid of the same cycle beyond load_en.
- rr_ptr: after each transfer whose beat has in_last=1, set to (granted+1) mod N_IN. It is unchanged otherwise.
- In MODE_SEL, rr_ptr is still maintained but unused.
- Out-of-range sel (N_IN not a power of two) or no valid input: no grant, all in_ready=0, no state change.
- sel changing mid-packet has no effect until the packet's last beat is transferred.
- Simultaneous output retire and new load in the same cycle: the new beat wins and out_valid stays 1.
- Reset mid-packet: the FSM returns to IDLE, the partial packet is discarded downstream, and no in_ready is asserted while rst_n is low.
- Inputs are sampled with no combinational path from in_data to out_data.

Decomposition:
- mux_pkg:
  - mux_mode_e (MODE_SEL, MODE_RR).
  - lock_state_e (IDLE, LOCKED).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: gnt_valid, gnt_idx.
  - Purely combinational rotate-priority search.
  - Instantiated once; bypassed in MODE_SEL.

Test Plan:
- Reset: drive in_valid=4'b1111 with rst_n=0 -> out_valid=0, out_data=0, in_ready=0. After release, first out_valid appears 1 cycle after the first in_ready handshake.
- MODE_SEL single beats: sel=2, in_valid=4'b0100, ch2 data=32'hA5A5_0002, last=1, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=32'hA5A5_0002, out_src=2, out_last=1.
- MODE_RR fairness: all 4 channels valid with single-beat packets, out_ready=1 -> out_src sequence 0,1,2,3,0,1,… at one beat per cycle.
- Packet lock: RR mode, ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 stay valid -> out_src=1 for 3 consecutive beats, then 2, then 0. In MODE_SEL, changing sel from 1 to 3 after beat 1 does not break the lock.
- Backpressure: out_ready=0 for 5 cycles with a beat held -> out_data stable, in_ready=0 throughout. On out_ready=1 the held beat retires and the next beat loads in the same cycle, with out_valid staying high.
- Boundaries: N_IN=3 with sel=3 -> no grant. Async rst_n pulse mid-packet -> FSM returns to IDLE and out_valid=0 immediately, without waiting for a clock edge.
